// File: rtl/hasher_pkg.sv
// hasher_pkg: shared definitions for the digest UART serializer.
//   state_t        FSM state encoding
//   ASCII_CR/LF    line terminator characters appended in hex-ASCII mode
//   nibble_to_hex  4-bit value -> upper-case ASCII hex digit
package hasher_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_HOLD     = 3'd2,
    S_WAIT_RDY = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // 0-9 -> 8'h30-8'h39, A-F -> 8'h41-8'h46
  function automatic logic [7:0] nibble_to_hex(input logic [3:0] nibble);
    if (nibble < 4'd10) nibble_to_hex = 8'h30 + {4'h0, nibble};
    else                nibble_to_hex = 8'h37 + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/hex_nibble_ascii.sv
// hex_nibble_ascii: combinational 4-bit -> ASCII hex digit encoder.
//   nibble  in   4  value to encode
//   ascii   out  8  upper-case ASCII hex character
module hex_nibble_ascii
  import hasher_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  assign ascii = nibble_to_hex(nibble);

endmodule

// File: rtl/digest_uart_serializer.sv
// digest_uart_serializer: captures one digest and streams it, MSB byte first,
// to a UART transmitter over a send/tx_ready handshake.
//
// Build option: define HASHER_HEX_ASCII_EN to emit each byte as two upper-case
// hex characters (high nibble first) followed by CR LF. Undefined: raw bytes.
//
// Ports:
//   clk           in   1         system clock
//   reset_n       in   1         synchronous active-low reset
//   digest_in     in   DIGEST_W  digest, sampled on accept
//   digest_valid  in   1         digest_in valid
//   digest_ready  out  1         high while idle
//   data_out      out  8         character to transmitter
//   send          out  1         one-cycle registered strobe
//   tx_ready      in   1         transmitter can accept
//   busy          out  1         transfer in progress
//   done          out  1         one-cycle pulse after the last character completes
module digest_uart_serializer
  import hasher_pkg::*;
#(
  parameter int DIGEST_W = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DIGEST_W-1:0] digest_in,
  input  logic                digest_valid,
  output logic                digest_ready,
  output logic [7:0]          data_out,
  output logic                send,
  input  logic                tx_ready,
  output logic                busy,
  output logic                done
);

  localparam int NBYTES = DIGEST_W / 8;
`ifdef HASHER_HEX_ASCII_EN
  localparam int NCHARS = 2 * NBYTES + 2;
`else
  localparam int NCHARS = NBYTES;
`endif
  localparam int IDX_W = $clog2(NCHARS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHARS - 1);

  if (((DIGEST_W % 8) != 0) || (DIGEST_W < 8)) begin : g_width_check
    $error("DIGEST_W must be a positive multiple of 8");
  end

  state_t              state, state_nxt;
  logic [DIGEST_W-1:0] shreg;
  logic [IDX_W-1:0]    idx;
  logic [7:0]          cur_char;
  logic                shift_now;
  logic                accept;
  logic                last_char;

  assign accept    = digest_valid && digest_ready;
  assign last_char = (idx == LAST_IDX);

  // Current character and whether the register advances a byte after it
`ifdef HASHER_HEX_ASCII_EN
  localparam logic [IDX_W-1:0] HEX_END = IDX_W'(2 * NBYTES);
  logic [7:0] top_byte;
  logic [3:0] nib;
  logic [7:0] hex_char;

  assign top_byte = shreg[DIGEST_W-1 -: 8];
  assign nib      = idx[0] ? top_byte[3:0] : top_byte[7:4];

  hex_nibble_ascii u_hex (
    .nibble (nib),
    .ascii  (hex_char)
  );

  always_comb begin
    cur_char = hex_char;
    if (idx == HEX_END)     cur_char = ASCII_CR;
    else if (idx > HEX_END) cur_char = ASCII_LF;
  end

  // Byte consumed once its low nibble has gone out
  assign shift_now = idx[0];
`else
  assign cur_char  = shreg[DIGEST_W-1 -: 8];
  assign shift_now = 1'b1;
`endif

  // State register plus datapath
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      shreg    <= '0;
      idx      <= '0;
      send     <= 1'b0;
      data_out <= 8'h00;
    end else begin
      state <= state_nxt;
      send  <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          shreg <= digest_in;
          idx   <= '0;
        end
        S_ISSUE: if (tx_ready) begin
          send     <= 1'b1;
          data_out <= cur_char;
        end
        S_WAIT_RDY: if (tx_ready && !last_char) begin
          idx <= idx + IDX_W'(1);
          if (shift_now) shreg <= shreg << 8;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (accept)   state_nxt = S_ISSUE;
      S_ISSUE:    if (tx_ready) state_nxt = S_HOLD;
      // Transmitter is dropping tx_ready this cycle; do not look at it
      S_HOLD:                   state_nxt = S_WAIT_RDY;
      S_WAIT_RDY: if (tx_ready) state_nxt = last_char ? S_DONE : S_ISSUE;
      S_DONE:                   state_nxt = S_IDLE;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  // Status outputs
  always_comb begin
    digest_ready = (state == S_IDLE);
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
  end

endmodule
